// File: rtl/ptdu_payload_tone_demap.sv
// Payload tone demap: serializes one constellation label per sub-carrier into a
// 1-bit stream, regenerating and cross-checking the per-OFDM-symbol end flag.
module ptdu_payload_tone_demap #(
  parameter int unsigned BITS   = 4,
  parameter int unsigned SC_NUM = 48
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] di_i,
  input  logic       di_vld_i,
  input  logic       di_sym_end_i,
  output logic       di_rdy_o,
  output logic       do_o,
  output logic       do_vld_o,
  output logic       do_sym_end_o,
  output logic       sym_err_o
);

  localparam int unsigned     CW       = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(BITS - 1);
  localparam logic [8:0]      SC_LAST  = 9'(SC_NUM - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e          state_q,    state_d;
  logic [BITS-1:0] shreg_q,    shreg_d;
  logic [CW-1:0]   bit_cnt_q,  bit_cnt_d;
  logic            end_q,      end_d;
  logic [8:0]      sc_cnt_q,   sc_cnt_d;
  logic            do_q,       do_d;
  logic            do_vld_q,   do_vld_d;
  logic            do_end_q,   do_end_d;
  logic            err_q,      err_d;

  logic last_bit;
  logic accept;
  logic sc_last;
  logic unused_di;

  // QPSK labels occupy the upper bits only; the rest of di_i is don't-care.
  assign unused_di = ^di_i;

  assign last_bit = (bit_cnt_q == LAST_BIT);
  assign di_rdy_o = (state_q == IDLE) || last_bit;
  assign accept   = di_vld_i && di_rdy_o;
  assign sc_last  = (sc_cnt_q == SC_LAST);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    end_d     = end_q;
    sc_cnt_d  = sc_cnt_q;
    do_d      = do_q;
    do_vld_d  = 1'b0;
    do_end_d  = 1'b0;
    err_d     = 1'b0;

    if (state_q == SHIFT) begin
      do_d      = shreg_q[0];
      do_vld_d  = 1'b1;
      shreg_d   = shreg_q >> 1;
      bit_cnt_d = bit_cnt_q + CW'(1);
      if (last_bit) begin
        do_end_d  = end_q;
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    end

    // A reload on the final bit overrides the IDLE return above, so labels stream gap-free.
    if (accept) begin
      shreg_d   = di_i[3 -: BITS];
      bit_cnt_d = '0;
      state_d   = SHIFT;
      end_d     = sc_last || di_sym_end_i;
      err_d     = sc_last ^ di_sym_end_i;
      sc_cnt_d  = (sc_last || di_sym_end_i) ? '0 : sc_cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      end_q     <= 1'b0;
      sc_cnt_q  <= '0;
      do_q      <= 1'b0;
      do_vld_q  <= 1'b0;
      do_end_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      end_q     <= end_d;
      sc_cnt_q  <= sc_cnt_d;
      do_q      <= do_d;
      do_vld_q  <= do_vld_d;
      do_end_q  <= do_end_d;
      err_q     <= err_d;
    end
  end

  assign do_o         = do_q;
  assign do_vld_o     = do_vld_q;
  assign do_sym_end_o = do_end_q;
  assign sym_err_o    = err_q;

endmodule

// File: tb/tb_ptdu_payload_tone_demap.sv
// Scoreboard bench for the payload tone demap: a 16QAM instance (u_a) and a QPSK
// instance (u_b), both with SC_NUM=4, driven by directed label sequences.
module tb_ptdu_payload_tone_demap;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] a_di, b_di;
  logic       a_vld, a_se, b_vld, b_se;
  logic       a_rdy, a_do, a_dv, a_de, a_err;
  logic       b_rdy, b_do, b_dv, b_de, b_err;

  ptdu_payload_tone_demap #(.BITS(4), .SC_NUM(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .di_i(a_di), .di_vld_i(a_vld), .di_sym_end_i(a_se), .di_rdy_o(a_rdy),
    .do_o(a_do), .do_vld_o(a_dv), .do_sym_end_o(a_de), .sym_err_o(a_err)
  );

  ptdu_payload_tone_demap #(.BITS(2), .SC_NUM(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .di_i(b_di), .di_vld_i(b_vld), .di_sym_end_i(b_se), .di_rdy_o(b_rdy),
    .do_o(b_do), .do_vld_o(b_dv), .do_sym_end_o(b_de), .sym_err_o(b_err)
  );

  typedef struct packed {
    logic d;
    logic e;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   runs_a, hi_a, err_a, runs_b, hi_b, err_b;
  logic pa = 1'b0, pb = 1'b0;
  exp_t ea, eb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected bit whenever an instance presents do_vld.
  always @(negedge clk) begin
    if (a_dv) begin
      if (qa.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL A unexpected do_vld: got 1 expected 0");
      end else begin
        ea = qa.pop_front();
        check("A do", 32'(a_do), 32'(ea.d));
        check("A do_sym_end", 32'(a_de), 32'(ea.e));
      end
    end
    if (b_dv) begin
      if (qb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL B unexpected do_vld: got 1 expected 0");
      end else begin
        eb = qb.pop_front();
        check("B do", 32'(b_do), 32'(eb.d));
        check("B do_sym_end", 32'(b_de), 32'(eb.e));
      end
    end
    if (a_dv && !pa) runs_a++;
    if (b_dv && !pb) runs_b++;
    if (a_dv) hi_a++;
    if (b_dv) hi_b++;
    if (a_err) err_a++;
    if (b_err) err_b++;
    pa = a_dv;
    pb = b_dv;
  end

  task automatic clear_stats();
    @(negedge clk);
    #1;
    runs_a = 0; hi_a = 0; err_a = 0;
    runs_b = 0; hi_b = 0; err_b = 0;
  endtask

  // Presents a label, queues its expected bits, returns just after the accepting edge.
  task automatic send(input bit sel, input logic [3:0] d, input logic se, input logic exp_end);
    int   bits = sel ? 2 : 4;
    int   n = 0;
    exp_t e;
    @(negedge clk);
    if (sel) begin b_di = d; b_se = se; b_vld = 1'b1; end
    else     begin a_di = d; a_se = se; a_vld = 1'b1; end
    for (int i = 0; i < bits; i++) begin
      e.d = d[4 - bits + i];
      e.e = exp_end && (i == bits - 1);
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
    end
    while (!(sel ? b_rdy : a_rdy)) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        vectors++; miscompares++;
        $display("FAIL %s di_rdy timeout: got 0 expected 1", sel ? "B" : "A");
        break;
      end
    end
    @(posedge clk);
  endtask

  task automatic stop(input bit sel);
    @(negedge clk);
    if (sel) b_vld = 1'b0;
    else     a_vld = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int   n = 0;
    logic done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      #1;
      n++;
      done = sel ? (qb.size() == 0 && !b_dv) : (qa.size() == 0 && !a_dv);
    end
    check(sel ? "B drain" : "A drain", 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    qa.delete();
    qb.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_stats(input string tag, input int runs, input int hi, input int errs,
                             input int exp_runs, input int exp_hi, input int exp_errs);
    check({tag, " do_vld runs"}, 32'(runs), 32'(exp_runs));
    check({tag, " do_vld cycles"}, 32'(hi), 32'(exp_hi));
    check({tag, " sym_err pulses"}, 32'(errs), 32'(exp_errs));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] l3 [8];
    logic [3:0] l4 [10];
    logic [3:0] rdy_exp;

    rst_n = 1'b0;
    a_di = '0; a_vld = 1'b0; a_se = 1'b0;
    b_di = '0; b_vld = 1'b0; b_se = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("A reset do", 32'(a_do), 32'd0);
    check("A reset do_vld", 32'(a_dv), 32'd0);
    check("A reset do_sym_end", 32'(a_de), 32'd0);
    check("A reset sym_err", 32'(a_err), 32'd0);
    check("A reset di_rdy", 32'(a_rdy), 32'd1);
    check("B reset di_rdy", 32'(b_rdy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single 16QAM label 1011 -> 1,1,0,1; ready low while bits 0..2 are pending.
    clear_stats();
    send(1'b0, 4'b1011, 1'b0, 1'b0);
    rdy_exp = 4'b1000;
    stop(1'b0);
    check("A rdy bit0", 32'(a_rdy), 32'(rdy_exp[0]));
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("A rdy during shift", 32'(a_rdy), 32'(rdy_exp[i]));
    end
    drain(1'b0);
    check("A rdy idle", 32'(a_rdy), 32'd1);
    check_stats("T1", runs_a, hi_a, err_a, 1, 4, 0);

    // Eight streamed labels, symbol ends on labels 4 and 8.
    do_reset();
    clear_stats();
    l3 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h0, 4'hA, 4'h5};
    for (int i = 0; i < 8; i++)
      send(1'b0, l3[i], (i == 3 || i == 7), (i == 3 || i == 7));
    stop(1'b0);
    drain(1'b0);
    check_stats("T3", runs_a, hi_a, err_a, 1, 32, 0);

    // Early end on label 2 resyncs; missing end on label 10 still flags the symbol end.
    do_reset();
    clear_stats();
    l4 = '{4'h3, 4'hC, 4'h6, 4'h9, 4'hE, 4'h7, 4'hB, 4'hD, 4'h1, 4'h8};
    for (int i = 0; i < 10; i++)
      send(1'b0, l4[i], (i == 1 || i == 5), (i == 1 || i == 5 || i == 9));
    stop(1'b0);
    drain(1'b0);
    check_stats("T4", runs_a, hi_a, err_a, 1, 40, 2);

    // QPSK: 10xx, 01xx -> 0,1,1,0 then two more labels closing the symbol.
    do_reset();
    clear_stats();
    send(1'b1, 4'b1011, 1'b0, 1'b0);
    send(1'b1, 4'b0100, 1'b0, 1'b0);
    send(1'b1, 4'b1100, 1'b0, 1'b0);
    send(1'b1, 4'b0011, 1'b1, 1'b1);
    stop(1'b1);
    drain(1'b1);
    check_stats("T2", runs_b, hi_b, err_b, 1, 8, 0);

    // Reset during bit 2 of the second label; sc_cnt must restart from zero.
    do_reset();
    send(1'b0, 4'h5, 1'b0, 1'b0);
    send(1'b0, 4'hA, 1'b0, 1'b0);
    stop(1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("T6 async do_vld", 32'(a_dv), 32'd0);
    check("T6 async do", 32'(a_do), 32'd0);
    check("T6 async do_sym_end", 32'(a_de), 32'd0);
    check("T6 async di_rdy", 32'(a_rdy), 32'd1);
    qa.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("T6 rdy after release", 32'(a_rdy), 32'd1);
    clear_stats();
    repeat (5) @(negedge clk);
    #1;
    check("T6 no stale output", 32'(hi_a), 32'd0);
    for (int i = 0; i < 4; i++)
      send(1'b0, 4'(i * 5 + 2), (i == 3), (i == 3));
    stop(1'b0);
    drain(1'b0);
    check_stats("T6", runs_a, hi_a, err_a, 1, 16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
